atm_controller: RTL and testbench

- Moore-style finite state machine (FSM) for a single-account ATM session: card insertion, PIN check, option menu, withdrawal amount check against available funds, balance display, card ejection.
- Sits between front-panel inputs (card sensor, keypad code/enter) and the display, cash-dispenser and card-ejector actuators.
- Expected PIN and account funds are supplied externally as static inputs.

---
 rtl/atm_pkg.sv | 58 +++++
 rtl/atm_edge_detect.sv | 23 ++
 rtl/atm_controller.sv | 150 +++++++++++++++
 tb/tb_atm_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM session controller: state encoding,
// display message codes, menu option codes and datapath widths.
package atm_pkg;

    localparam int CODE_W  = 14;
    localparam int FUNDS_W = 32;

    // Default number of consecutive wrong PINs tolerated when lockout is built in.
    localparam int MAX_TRIES_DEF = 3;

    // Menu option codes entered on the keypad while the option menu is shown.
    localparam int OPT_WITHDRAW_CODE = 1;
    localparam int OPT_BALANCE_CODE  = 2;
    localparam int OPT_EXIT_CODE     = 3;

    // Display message codes; 9..15 are never driven.
    localparam logic [3:0] MSG_INSERT   = 4'd0;
    localparam logic [3:0] MSG_PIN      = 4'd1;
    localparam logic [3:0] MSG_BADPIN   = 4'd2;
    localparam logic [3:0] MSG_OPTION   = 4'd3;
    localparam logic [3:0] MSG_AMOUNT   = 4'd4;
    localparam logic [3:0] MSG_NOFUNDS  = 4'd5;
    localparam logic [3:0] MSG_CASH     = 4'd6;
    localparam logic [3:0] MSG_CARDBACK = 4'd7;
    localparam logic [3:0] MSG_BALANCE  = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PIN     = 4'd1,
        ST_BAD_PIN = 4'd2,
        ST_MENU    = 4'd3,
        ST_AMOUNT  = 4'd4,
        ST_NOFUNDS = 4'd5,
        ST_CASH    = 4'd6,
        ST_EJECT   = 4'd7,
        ST_BALANCE = 4'd8
    } atm_state_t;

    // Display message shown in each state.
    function automatic logic [3:0] msg_of_state(input atm_state_t st);
        logic [3:0] m;
        m = MSG_INSERT;
        case (st)
            ST_IDLE:    m = MSG_INSERT;
            ST_PIN:     m = MSG_PIN;
            ST_BAD_PIN: m = MSG_BADPIN;
            ST_MENU:    m = MSG_OPTION;
            ST_AMOUNT:  m = MSG_AMOUNT;
            ST_NOFUNDS: m = MSG_NOFUNDS;
            ST_CASH:    m = MSG_CASH;
            ST_EJECT:   m = MSG_CARDBACK;
            ST_BALANCE: m = MSG_BALANCE;
            default:    m = MSG_INSERT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/atm_edge_detect.sv
// Keypad confirm strobe: one-cycle pulse on the rising edge of enter, so a
// held key issues a single command.
module atm_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic enter,
    output logic cmd
);

    logic enter_d;

    // Previous-cycle copy of enter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_d <= 1'b0;
        end else begin
            enter_d <= enter;
        end
    end

    assign cmd = enter & ~enter_d;

endmodule

// File: rtl/atm_controller.sv
// ATM session controller: card insertion, PIN check, option menu, withdrawal
// against available funds, balance display and card ejection.
// Optional build macro ATM_PIN_LOCKOUT_EN: after MAX_TRIES consecutive wrong
// PINs the card is ejected instead of prompting again. Without it, retries
// are unlimited and no try counter is built.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no card, waiting for insertion
// PIN      | card present, waiting for PIN entry
// BAD_PIN  | one-cycle wrong-PIN notice
// MENU     | waiting for option (withdraw / balance / exit)
// AMOUNT   | waiting for withdrawal amount (0 cancels)
// NOFUNDS  | one-cycle insufficient-funds notice
// CASH     | one-cycle dispense strobe
// EJECT    | card being returned, wait for removal
// BALANCE  | one-cycle balance display
module atm_controller
    import atm_pkg::*;
#(
    parameter int MAX_TRIES    = MAX_TRIES_DEF,
    parameter int OPT_WITHDRAW = OPT_WITHDRAW_CODE,
    parameter int OPT_BALANCE  = OPT_BALANCE_CODE,
    parameter int OPT_EXIT     = OPT_EXIT_CODE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               card,
    input  logic               enter,
    input  logic [CODE_W-1:0]  code,
    input  logic [CODE_W-1:0]  exp_pin,
    input  logic [FUNDS_W-1:0] funds,
    output logic [3:0]         msg,
    output logic               cash_trap,
    output logic               eject_card
);

    if (MAX_TRIES < 1) begin : g_bad_max_tries
        $error("MAX_TRIES must be at least 1");
    end

    atm_state_t state;
    atm_state_t state_nxt;
    logic       cmd;
    logic       pin_ok;
    logic       amount_ok;
    logic       lockout;

    atm_edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .enter (enter),
        .cmd   (cmd)
    );

    assign pin_ok    = (code == exp_pin);
    // Amount equal to funds is still a valid withdrawal.
    assign amount_ok = ({{(FUNDS_W-CODE_W){1'b0}}, code} <= funds);

`ifdef ATM_PIN_LOCKOUT_EN
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic [TRY_W-1:0] try_cnt;

    // Consecutive wrong-PIN count; cleared on a good PIN or when the session ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            try_cnt <= '0;
        end else if (state_nxt == ST_IDLE) begin
            try_cnt <= '0;
        end else if (state == ST_PIN && card && cmd) begin
            if (pin_ok) begin
                try_cnt <= '0;
            end else if (try_cnt != TRY_W'(MAX_TRIES)) begin
                try_cnt <= try_cnt + 1'b1;
            end
        end
    end

    assign lockout = (try_cnt >= TRY_W'(MAX_TRIES));
`else
    assign lockout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; card removal outranks any keypad command.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (card) state_nxt = ST_PIN;
            end
            ST_PIN: begin
                if (!card)    state_nxt = ST_IDLE;
                else if (cmd) state_nxt = pin_ok ? ST_MENU : ST_BAD_PIN;
            end
            ST_BAD_PIN: begin
                if (!card)        state_nxt = ST_IDLE;
                else if (lockout) state_nxt = ST_EJECT;
                else              state_nxt = ST_PIN;
            end
            ST_MENU: begin
                if (!card) begin
                    state_nxt = ST_IDLE;
                end else if (cmd) begin
                    if (code == CODE_W'(OPT_WITHDRAW))     state_nxt = ST_AMOUNT;
                    else if (code == CODE_W'(OPT_BALANCE)) state_nxt = ST_BALANCE;
                    else if (code == CODE_W'(OPT_EXIT))    state_nxt = ST_EJECT;
                end
            end
            ST_AMOUNT: begin
                if (!card) begin
                    state_nxt = ST_IDLE;
                end else if (cmd) begin
                    if (code == '0)     state_nxt = ST_MENU;
                    else if (amount_ok) state_nxt = ST_CASH;
                    else                state_nxt = ST_NOFUNDS;
                end
            end
            ST_NOFUNDS, ST_BALANCE: begin
                state_nxt = card ? ST_MENU : ST_IDLE;
            end
            ST_CASH: begin
                state_nxt = ST_EJECT;
            end
            ST_EJECT: begin
                if (!card) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        msg        = msg_of_state(state);
        cash_trap  = (state == ST_CASH);
        eject_card = (state == ST_EJECT);
    end

endmodule

// File: tb/tb_atm_controller.sv
// Self-checking bench for atm_controller: directed scenarios plus randomized
// sessions checked against a transaction-level model of the session rules.
module tb_atm_controller;

    localparam int TB_MAX_TRIES = 3;

    logic        clk;
    logic        rst_n;
    logic        card;
    logic        enter;
    logic [13:0] code;
    logic [13:0] exp_pin;
    logic [31:0] funds;
    logic [3:0]  msg;
    logic        cash_trap;
    logic        eject_card;

    int total_cnt = 0;
    int pass_cnt  = 0;

    atm_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .card       (card),
        .enter      (enter),
        .code       (code),
        .exp_pin    (exp_pin),
        .funds      (funds),
        .msg        (msg),
        .cash_trap  (cash_trap),
        .eject_card (eject_card)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One keypad command: enter low for a cycle, then high for one cycle.
    task automatic press(input logic [13:0] c);
        enter = 1'b0;
        step();
        code  = c;
        enter = 1'b1;
        step();
        enter = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; card = 1'b0; enter = 1'b0; code = '0;
        exp_pin = 14'd1234; funds = 32'd224;
        step(); step();
        total_cnt++; if (msg !== 4'd0) $display("FAIL reset_msg: got %0d required 0", msg); else pass_cnt++;
        total_cnt++; if (cash_trap !== 1'b0) $display("FAIL reset_cash: got %b required 0", cash_trap); else pass_cnt++;
        total_cnt++; if (eject_card !== 1'b0) $display("FAIL reset_eject: got %b required 0", eject_card); else pass_cnt++;
        rst_n = 1'b1;
        step(); step();
        total_cnt++; if (msg !== 4'd0) $display("FAIL idle_no_card: got %0d required 0", msg); else pass_cnt++;
    endtask

    task automatic test_happy_withdrawal();
        exp_pin = 14'd1234; funds = 32'd224;
        card = 1'b1; step();
        total_cnt++; if (msg !== 4'd1) $display("FAIL happy_pin: got %0d required 1", msg); else pass_cnt++;
        press(14'd1234);
        total_cnt++; if (msg !== 4'd3) $display("FAIL happy_menu: got %0d required 3", msg); else pass_cnt++;
        press(14'd1);
        total_cnt++; if (msg !== 4'd4) $display("FAIL happy_amount: got %0d required 4", msg); else pass_cnt++;
        press(14'd25);
        total_cnt++; if (msg !== 4'd6 || cash_trap !== 1'b1) $display("FAIL happy_cash: got msg=%0d cash=%b required 6/1", msg, cash_trap); else pass_cnt++;
        step();
        total_cnt++; if (msg !== 4'd7 || cash_trap !== 1'b0 || eject_card !== 1'b1) $display("FAIL happy_eject: got msg=%0d cash=%b eject=%b required 7/0/1", msg, cash_trap, eject_card); else pass_cnt++;
        repeat (3) step();
        total_cnt++; if (msg !== 4'd7 || eject_card !== 1'b1) $display("FAIL happy_eject_hold: got msg=%0d eject=%b required 7/1", msg, eject_card); else pass_cnt++;
        card = 1'b0; step();
        total_cnt++; if (msg !== 4'd0 || eject_card !== 1'b0) $display("FAIL happy_idle: got msg=%0d eject=%b required 0/0", msg, eject_card); else pass_cnt++;
    endtask

    task automatic test_wrong_pin();
        exp_pin = 14'd1234;
        card = 1'b1; step();
        press(14'd1111);
        total_cnt++; if (msg !== 4'd2) $display("FAIL wrong_pin_bad: got %0d required 2", msg); else pass_cnt++;
        step();
        total_cnt++; if (msg !== 4'd1) $display("FAIL wrong_pin_retry: got %0d required 1", msg); else pass_cnt++;
        press(14'd1234);
        total_cnt++; if (msg !== 4'd3) $display("FAIL wrong_pin_then_ok: got %0d required 3", msg); else pass_cnt++;
        card = 1'b0; step();
        total_cnt++; if (msg !== 4'd0) $display("FAIL wrong_pin_remove: got %0d required 0", msg); else pass_cnt++;
    endtask

    task automatic test_funds();
        exp_pin = 14'd1234; funds = 32'd224;
        card = 1'b1; step();
        press(14'd1234);
        press(14'd1);
        press(14'd225);
        total_cnt++; if (msg !== 4'd5 || cash_trap !== 1'b0) $display("FAIL nofunds: got msg=%0d cash=%b required 5/0", msg, cash_trap); else pass_cnt++;
        step();
        total_cnt++; if (msg !== 4'd3 || cash_trap !== 1'b0) $display("FAIL nofunds_menu: got msg=%0d cash=%b required 3/0", msg, cash_trap); else pass_cnt++;
        press(14'd1);
        press(14'd0);
        total_cnt++; if (msg !== 4'd3) $display("FAIL amount_cancel: got %0d required 3", msg); else pass_cnt++;
        press(14'd1);
        press(14'd224);
        total_cnt++; if (msg !== 4'd6 || cash_trap !== 1'b1) $display("FAIL exact_funds: got msg=%0d cash=%b required 6/1", msg, cash_trap); else pass_cnt++;
        step();
        card = 1'b0; step();
        total_cnt++; if (msg !== 4'd0) $display("FAIL funds_idle: got %0d required 0", msg); else pass_cnt++;
    endtask

    task automatic test_balance_exit();
        exp_pin = 14'd1234;
        card = 1'b1; step();
        press(14'd1234);
        press(14'd2);
        total_cnt++; if (msg !== 4'd8) $display("FAIL balance: got %0d required 8", msg); else pass_cnt++;
        step();
        total_cnt++; if (msg !== 4'd3) $display("FAIL balance_menu: got %0d required 3", msg); else pass_cnt++;
        press(14'd9);
        step();
        total_cnt++; if (msg !== 4'd3) $display("FAIL bad_option: got %0d required 3", msg); else pass_cnt++;
        press(14'd3);
        total_cnt++; if (msg !== 4'd7 || eject_card !== 1'b1) $display("FAIL exit: got msg=%0d eject=%b required 7/1", msg, eject_card); else pass_cnt++;
        card = 1'b0; step();
        total_cnt++; if (msg !== 4'd0) $display("FAIL exit_idle: got %0d required 0", msg); else pass_cnt++;
    endtask

    task automatic test_held_enter_abort();
        // PIN equal to the withdraw option: a second command would reach AMOUNT.
        exp_pin = 14'd1;
        card = 1'b1; step();
        code = 14'd1; enter = 1'b0; step();
        enter = 1'b1; step();
        total_cnt++; if (msg !== 4'd3) $display("FAIL held_first: got %0d required 3", msg); else pass_cnt++;
        repeat (4) step();
        total_cnt++; if (msg !== 4'd3) $display("FAIL held_single_cmd: got %0d required 3", msg); else pass_cnt++;
        enter = 1'b0;
        press(14'd1);
        total_cnt++; if (msg !== 4'd4) $display("FAIL held_then_amount: got %0d required 4", msg); else pass_cnt++;
        card = 1'b0; step();
        total_cnt++; if (msg !== 4'd0) $display("FAIL abort_amount: got %0d required 0", msg); else pass_cnt++;
        // Card pulled in the same cycle as a menu command.
        card = 1'b1; step();
        press(14'd1);
        enter = 1'b0; step();
        code = 14'd1; enter = 1'b1; card = 1'b0; step();
        enter = 1'b0;
        total_cnt++; if (msg !== 4'd0) $display("FAIL card_priority: got %0d required 0", msg); else pass_cnt++;
    endtask

    task automatic test_reset_mid_cash();
        exp_pin = 14'd1234; funds = 32'd224;
        card = 1'b1; step();
        press(14'd1234);
        press(14'd1);
        press(14'd25);
        total_cnt++; if (msg !== 4'd6) $display("FAIL pre_reset_cash: got %0d required 6", msg); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++; if (msg !== 4'd0 || cash_trap !== 1'b0 || eject_card !== 1'b0) $display("FAIL async_reset: got msg=%0d cash=%b eject=%b required 0/0/0", msg, cash_trap, eject_card); else pass_cnt++;
        card = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        total_cnt++; if (msg !== 4'd0 || cash_trap !== 1'b0) $display("FAIL post_reset: got msg=%0d cash=%b required 0/0", msg, cash_trap); else pass_cnt++;
    endtask

`ifdef ATM_PIN_LOCKOUT_EN
    task automatic test_pin_lockout();
        exp_pin = 14'd1234;
        card = 1'b1; step();
        for (int i = 0; i < TB_MAX_TRIES - 1; i++) begin
            press(14'd1111);
            total_cnt++; if (msg !== 4'd2) $display("FAIL lockout_bad%0d: got %0d required 2", i, msg); else pass_cnt++;
            step();
            total_cnt++; if (msg !== 4'd1) $display("FAIL lockout_retry%0d: got %0d required 1", i, msg); else pass_cnt++;
        end
        press(14'd1111);
        total_cnt++; if (msg !== 4'd2) $display("FAIL lockout_last_bad: got %0d required 2", msg); else pass_cnt++;
        step();
        total_cnt++; if (msg !== 4'd7 || eject_card !== 1'b1) $display("FAIL lockout_eject: got msg=%0d eject=%b required 7/1", msg, eject_card); else pass_cnt++;
        press(14'd1234);
        repeat (2) step();
        total_cnt++; if (msg !== 4'd7) $display("FAIL lockout_stays: got %0d required 7", msg); else pass_cnt++;
        card = 1'b0; step();
        total_cnt++; if (msg !== 4'd0) $display("FAIL lockout_idle: got %0d required 0", msg); else pass_cnt++;
        // New session starts with a fresh try count.
        card = 1'b1; step();
        press(14'd1111);
        step();
        total_cnt++; if (msg !== 4'd1) $display("FAIL lockout_cleared: got %0d required 1", msg); else pass_cnt++;
        card = 1'b0; step();
    endtask
`else
    task automatic test_unlimited_retries();
        exp_pin = 14'd1234;
        card = 1'b1; step();
        for (int i = 0; i < TB_MAX_TRIES + 2; i++) begin
            press(14'd1111);
            step();
            total_cnt++; if (msg !== 4'd1) $display("FAIL retry%0d: got %0d required 1", i, msg); else pass_cnt++;
        end
        press(14'd1234);
        total_cnt++; if (msg !== 4'd3) $display("FAIL retry_then_ok: got %0d required 3", msg); else pass_cnt++;
        card = 1'b0; step();
    endtask
`endif

    // Randomized sessions. Expected messages come from the session rules:
    // amount 0 cancels to the menu, amount <= funds dispenses then returns
    // the card, anything larger shows the no-funds notice then the menu.
    task automatic test_random_sessions();
        int    n_bad;
        int    op;
        int    sel;
        int    amt;
        int    bad;
        bit    ended;
        for (int s = 0; s < 25; s++) begin
            exp_pin = 14'($urandom_range(0, 16383));
            sel = $urandom_range(0, 2);
            if (sel == 0)      funds = 32'($urandom_range(0, 300));
            else if (sel == 1) funds = 32'($urandom_range(16000, 16400));
            else               funds = $urandom;
            card = 1'b1; step();
            total_cnt++; if (msg !== 4'd1) $display("FAIL rnd%0d_pin: got %0d required 1", s, msg); else pass_cnt++;
            n_bad = $urandom_range(0, TB_MAX_TRIES - 1);
            for (int b = 0; b < n_bad; b++) begin
                bad = (int'(exp_pin) + int'($urandom_range(1, 16383))) % 16384;
                press(14'(bad));
                total_cnt++; if (msg !== 4'd2) $display("FAIL rnd%0d_badpin: got %0d required 2", s, msg); else pass_cnt++;
                step();
                total_cnt++; if (msg !== 4'd1) $display("FAIL rnd%0d_retry: got %0d required 1", s, msg); else pass_cnt++;
            end
            press(exp_pin);
            total_cnt++; if (msg !== 4'd3) $display("FAIL rnd%0d_menu: got %0d required 3", s, msg); else pass_cnt++;
            ended = 1'b0;
            for (int k = 0; k < 5 && !ended; k++) begin
                op = $urandom_range(0, 4);
                if (op <= 1) begin
                    press(14'd1);
                    total_cnt++; if (msg !== 4'd4) $display("FAIL rnd%0d_amount: got %0d required 4", s, msg); else pass_cnt++;
                    sel = $urandom_range(0, 3);
                    if (sel == 0)                       amt = 0;
                    else if (sel == 1 && funds < 16384) amt = int'(funds);
                    else if (sel == 2 && funds < 16383) amt = int'(funds) + 1;
                    else                                amt = $urandom_range(1, 16383);
                    press(14'(amt));
                    if (amt == 0) begin
                        total_cnt++; if (msg !== 4'd3) $display("FAIL rnd%0d_cancel: got %0d required 3", s, msg); else pass_cnt++;
                    end else if (longint'(amt) <= longint'(funds)) begin
                        total_cnt++; if (msg !== 4'd6 || cash_trap !== 1'b1) $display("FAIL rnd%0d_cash amt=%0d funds=%0d: got msg=%0d cash=%b required 6/1", s, amt, funds, msg, cash_trap); else pass_cnt++;
                        step();
                        total_cnt++; if (msg !== 4'd7) $display("FAIL rnd%0d_cardback: got %0d required 7", s, msg); else pass_cnt++;
                        ended = 1'b1;
                    end else begin
                        total_cnt++; if (msg !== 4'd5 || cash_trap !== 1'b0) $display("FAIL rnd%0d_nofunds amt=%0d funds=%0d: got msg=%0d cash=%b required 5/0", s, amt, funds, msg, cash_trap); else pass_cnt++;
                        step();
                        total_cnt++; if (msg !== 4'd3) $display("FAIL rnd%0d_nofunds_menu: got %0d required 3", s, msg); else pass_cnt++;
                    end
                end else if (op == 2) begin
                    press(14'd2);
                    total_cnt++; if (msg !== 4'd8) $display("FAIL rnd%0d_balance: got %0d required 8", s, msg); else pass_cnt++;
                    step();
                    total_cnt++; if (msg !== 4'd3) $display("FAIL rnd%0d_balance_menu: got %0d required 3", s, msg); else pass_cnt++;
                end else if (op == 3) begin
                    press(14'($urandom_range(4, 16383)));
                    step();
                    total_cnt++; if (msg !== 4'd3) $display("FAIL rnd%0d_invalid_opt: got %0d required 3", s, msg); else pass_cnt++;
                end else begin
                    press(14'd3);
                    total_cnt++; if (msg !== 4'd7 || eject_card !== 1'b1) $display("FAIL rnd%0d_exit: got msg=%0d eject=%b required 7/1", s, msg, eject_card); else pass_cnt++;
                    ended = 1'b1;
                end
            end
            card = 1'b0; step();
            total_cnt++; if (msg !== 4'd0) $display("FAIL rnd%0d_idle: got %0d required 0", s, msg); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_happy_withdrawal();
        test_wrong_pin();
        test_funds();
        test_balance_exit();
        test_held_enter_abort();
        test_reset_mid_cash();
`ifdef ATM_PIN_LOCKOUT_EN
        test_pin_lockout();
`else
        test_unlimited_retries();
`endif
        test_random_sessions();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
